mem_ctrl: RTL and testbench

//  Single owner of the byte-wide RAM/IO port. Arbitrates between instruction fetches
//  (icache) and data loads/stores (dcache).

---
 rtl/mem_ctrl_pkg.sv | 32 +++
 rtl/mem_ctrl_if.sv | 38 +++
 rtl/mem_ctrl.sv | 156 +++++++++++++++
 tb/tb_mem_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory controller: bus widths, the IO window base,
// FSM state encodings and the little-endian load-merge helper.
package mem_ctrl_pkg;

  localparam int unsigned AddrBus = 32;
  localparam int unsigned DataBus = 32;
  localparam int unsigned LenBus  = 3;
  localparam int unsigned WaitBus = 2;

  localparam logic [AddrBus-1:0] IoBaseDefault = 32'h0003_0000;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRd   = 2'd1,
    StWr   = 2'd2
  } state_e;

  // Combine the 24-bit shift buffer (earlier bytes, newest at the top) with the
  // byte arriving on the final beat. Bits above the request length are zero.
  function automatic logic [DataBus-1:0] merge_load(input logic [23:0]       sh,
                                                    input logic [7:0]        last,
                                                    input logic [LenBus-1:0] len);
    logic [DataBus-1:0] r;
    case (len)
      3'd1:    r = {24'h0, last};
      3'd2:    r = {16'h0, last, sh[23:16]};
      default: r = {last, sh};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Bundle of the icache, dcache and RAM/IO signals around mem_ctrl.
//  slave  : the controller side (mem_ctrl)
//  master : the environment side (caches, RAM, IO buffer)
interface mem_ctrl_if;
  import mem_ctrl_pkg::*;

  // icache
  logic                iIC_en;
  logic [AddrBus-1:0]  iIC_pc;
  logic                oIC_done;
  logic [DataBus-1:0]  oIC_dt;
  // dcache
  logic                iDC_en;
  logic                iDC_ls;
  logic [AddrBus-1:0]  iDC_pc;
  logic [DataBus-1:0]  iDC_dt;
  logic [LenBus-1:0]   iDC_len;
  logic                oDC_done;
  logic [DataBus-1:0]  oDC_dt;
  logic [WaitBus-1:0]  oWait;
  // RAM / IO
  logic [7:0]          iRAM_dt;
  logic [7:0]          oRAM_dt;
  logic [AddrBus-1:0]  oRAM_a;
  logic                oRAM_wr;
  logic                iIO_full;

  modport slave (
    input  iIC_en, iIC_pc, iDC_en, iDC_ls, iDC_pc, iDC_dt, iDC_len, iRAM_dt, iIO_full,
    output oIC_done, oIC_dt, oDC_done, oDC_dt, oWait, oRAM_dt, oRAM_a, oRAM_wr
  );

  modport master (
    output iIC_en, iIC_pc, iDC_en, iDC_ls, iDC_pc, iDC_dt, iDC_len, iRAM_dt, iIO_full,
    input  oIC_done, oIC_dt, oDC_done, oDC_dt, oWait, oRAM_dt, oRAM_a, oRAM_wr
  );

endinterface

// File: rtl/mem_ctrl.sv
// Single owner of the byte-wide RAM/IO port. Arbitrates icache fetches against
// dcache loads/stores (dcache wins), serialises each request into byte beats and
// assembles load data little-endian.
//  clk, rst : clock, asynchronous active-high reset
//  rdy      : global enable, low freezes all state and blocks writes
//  bus      : mem_ctrl_if.slave (icache, dcache, RAM/IO signals)
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter logic [AddrBus-1:0] IO_BASE = IoBaseDefault
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rdy,
  mem_ctrl_if.slave  bus
);

  state_e              state_q, state_d;
  logic [2:0]          cnt_q;
  logic                cur_ic_q;
  logic [AddrBus-1:0]  cur_pc_q;
  logic [DataBus-1:0]  cur_dt_q;
  logic [LenBus-1:0]   cur_len_q;
  logic                slot_v_q, slot_ls_q;
  logic [AddrBus-1:0]  slot_pc_q;
  logic [DataBus-1:0]  slot_dt_q;
  logic [LenBus-1:0]   slot_len_q;
  logic [23:0]         sh_q;
  logic                ic_done_q, dc_done_q;
  logic [DataBus-1:0]  ic_dt_q, dc_dt_q;

  logic                ic_req, dc_accept, dc_req, dc_ls;
  logic [AddrBus-1:0]  dc_pc, beat_a;
  logic [DataBus-1:0]  dc_dt;
  logic [LenBus-1:0]   dc_len;
  logic                io_stall, rd_last, wr_last;

  // Icache is ignored while its done pulse is out; dcache is re-armed only after
  // the slot has been released on the edge following its done pulse.
  always_comb begin
    ic_req    = bus.iIC_en && !ic_done_q;
    dc_accept = bus.iDC_en && !slot_v_q;
    dc_req    = (slot_v_q && !dc_done_q) || dc_accept;
    dc_ls     = slot_v_q ? slot_ls_q  : bus.iDC_ls;
    dc_pc     = slot_v_q ? slot_pc_q  : bus.iDC_pc;
    dc_dt     = slot_v_q ? slot_dt_q  : bus.iDC_dt;
    dc_len    = slot_v_q ? slot_len_q : bus.iDC_len;
    beat_a    = cur_pc_q + AddrBus'(cnt_q);
    io_stall  = (state_q == StWr) && (beat_a >= IO_BASE) && bus.iIO_full;
    rd_last   = (state_q == StRd) && (cnt_q == cur_len_q);
    wr_last   = (state_q == StWr) && !io_stall && (cnt_q == cur_len_q - 3'd1);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else if (rdy) begin
      state_q <= state_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (dc_req)      state_d = dc_ls ? StWr : StRd;
        else if (ic_req) state_d = StRd;
      end
      StRd:    if (rd_last) state_d = StIdle;
      StWr:    if (wr_last) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    bus.oRAM_wr = rdy && (state_q == StWr) && !io_stall;
    bus.oRAM_a  = (state_q == StIdle) ? '0 : beat_a;
    bus.oRAM_dt = (state_q == StWr) ? cur_dt_q[{cnt_q[1:0], 3'b000} +: 8] : 8'h00;
    bus.oWait   = {slot_v_q, ic_req && !((state_q != StIdle) && cur_ic_q)};
  end

  assign bus.oIC_done = ic_done_q;
  assign bus.oIC_dt   = ic_dt_q;
  assign bus.oDC_done = dc_done_q;
  assign bus.oDC_dt   = dc_dt_q;

  // Datapath: pending slot, current request, beat counter, load assembly
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      cur_ic_q   <= 1'b0;
      cur_pc_q   <= '0;
      cur_dt_q   <= '0;
      cur_len_q  <= '0;
      slot_v_q   <= 1'b0;
      slot_ls_q  <= 1'b0;
      slot_pc_q  <= '0;
      slot_dt_q  <= '0;
      slot_len_q <= '0;
      sh_q       <= '0;
      ic_done_q  <= 1'b0;
      dc_done_q  <= 1'b0;
      ic_dt_q    <= '0;
      dc_dt_q    <= '0;
    end else if (rdy) begin
      ic_done_q <= 1'b0;
      dc_done_q <= 1'b0;
      if (dc_done_q) begin
        slot_v_q <= 1'b0;
      end else if (dc_accept) begin
        slot_v_q   <= 1'b1;
        slot_ls_q  <= bus.iDC_ls;
        slot_pc_q  <= bus.iDC_pc;
        slot_dt_q  <= bus.iDC_dt;
        slot_len_q <= bus.iDC_len;
      end
      unique case (state_q)
        StIdle: begin
          if (dc_req || ic_req) begin
            cnt_q     <= '0;
            cur_ic_q  <= !dc_req;
            cur_pc_q  <= dc_req ? dc_pc : bus.iIC_pc;
            cur_len_q <= dc_req ? dc_len : 3'd4;
            cur_dt_q  <= dc_dt;
          end
        end
        StRd: begin
          // The first shift takes a don't-care byte; merge_load only uses the
          // slices filled by real bytes.
          cnt_q <= cnt_q + 3'd1;
          sh_q  <= {bus.iRAM_dt, sh_q[23:8]};
          if (rd_last) begin
            if (cur_ic_q) begin
              ic_done_q <= 1'b1;
              ic_dt_q   <= merge_load(sh_q, bus.iRAM_dt, cur_len_q);
            end else begin
              dc_done_q <= 1'b1;
              dc_dt_q   <= merge_load(sh_q, bus.iRAM_dt, cur_len_q);
            end
          end
        end
        StWr: begin
          if (!io_stall) begin
            cnt_q <= cnt_q + 3'd1;
            if (wr_last) dc_done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic rdy;
  logic ram_init;

  mem_ctrl_if bus();

  mem_ctrl dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Byte RAM: read data one cycle after the address, write on the edge.
  logic [7:0] ram [0:65535];
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 65536; i++) ram[i] <= 8'h00;
      ram[16'h0100] <= 8'h93;
      ram[16'h0101] <= 8'h00;
      ram[16'h0102] <= 8'h10;
      ram[16'h0103] <= 8'h00;
      ram[16'h0010] <= 8'h5A;
    end else if (bus.oRAM_wr) begin
      ram[bus.oRAM_a[15:0]] <= bus.oRAM_dt;
    end
    bus.iRAM_dt <= ram[bus.oRAM_a[15:0]];
  end

  typedef struct {
    logic [31:0] a;
    logic [7:0]  d;
  } wr_t;
  wr_t wlog[$];
  always @(negedge clk) if (bus.oRAM_wr === 1'b1) wlog.push_back('{bus.oRAM_a, bus.oRAM_dt});

  typedef struct {
    bit          ic;
    bit          ls;
    logic [31:0] pc;
    logic [31:0] dt;
    logic [2:0]  len;
    logic [31:0] exp_dt;
    int          exp_lat;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int lat;
    bit ok;
    int wbase;
    logic [31:0] sh;
    @(negedge clk);
    wbase = wlog.size();
    if (v.ic) begin
      bus.iIC_en = 1'b1;
      bus.iIC_pc = v.pc;
    end else begin
      bus.iDC_en  = 1'b1;
      bus.iDC_ls  = v.ls;
      bus.iDC_pc  = v.pc;
      bus.iDC_dt  = v.dt;
      bus.iDC_len = v.len;
    end
    @(posedge clk); #1;
    bus.iDC_en = 1'b0;
    lat = 0;
    ok  = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk); #1;
      if (v.ic ? bus.oIC_done : bus.oDC_done) begin
        lat = n;
        ok  = 1'b1;
        break;
      end
    end
    bus.iIC_en = 1'b0;
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s timeout: no done within 60 edges", tag);
    end else begin
      check({tag, " latency"}, 32'(lat), 32'(v.exp_lat));
      if (v.ic) check({tag, " oIC_dt"}, bus.oIC_dt, v.exp_dt);
      else if (!v.ls) check({tag, " oDC_dt"}, bus.oDC_dt, v.exp_dt);
      else begin
        check({tag, " nwrites"}, 32'(wlog.size() - wbase), 32'(v.len));
        for (int i = 0; i < int'(v.len); i++) begin
          if (wbase + i < wlog.size()) begin
            sh = v.dt >> (8 * i);
            check({tag, " wr addr"}, wlog[wbase+i].a, v.pc + 32'(i));
            check({tag, " wr data"}, {24'h0, wlog[wbase+i].d}, {24'h0, sh[7:0]});
          end
        end
      end
    end
    @(posedge clk); #1;
    check({tag, " idle wait/done"}, {28'h0, bus.oWait, bus.oIC_done, bus.oDC_done}, 32'h0);
  endtask

  vec_t vecs[8];

  initial begin
    int dc_at, ic_at, bad_wait, ndone, done_c, fall_c, zeros, n, wr_bad, wbase;
    logic [31:0] dc_dt_cap, ic_dt_cap;
    vec_t v;

    vecs[0] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0,          3'd4, 32'h0010_0093, 5};
    vecs[1] = '{1'b0, 1'b1, 32'h0000_0200, 32'hDEAD_BEEF,  3'd4, 32'h0,         4};
    vecs[2] = '{1'b0, 1'b0, 32'h0000_0202, 32'h0,          3'd2, 32'h0000_DEAD, 3};
    vecs[3] = '{1'b0, 1'b0, 32'h0000_0200, 32'h0,          3'd4, 32'hDEAD_BEEF, 5};
    vecs[4] = '{1'b0, 1'b0, 32'h0000_0201, 32'h0,          3'd1, 32'h0000_00BE, 2};
    vecs[5] = '{1'b0, 1'b1, 32'h0000_0300, 32'h1234_5678,  3'd2, 32'h0,         2};
    vecs[6] = '{1'b0, 1'b0, 32'h0000_0300, 32'h0,          3'd4, 32'h0000_5678, 5};
    vecs[7] = '{1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0000_CAFE,  3'd2, 32'h0,         2};

    rst = 1'b1; rdy = 1'b1; ram_init = 1'b1;
    bus.iIC_en = 1'b0; bus.iIC_pc = '0;
    bus.iDC_en = 1'b0; bus.iDC_ls = 1'b0; bus.iDC_pc = '0; bus.iDC_dt = '0; bus.iDC_len = 3'd1;
    bus.iIO_full = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    ram_init = 1'b0;
    check("reset dones", {30'h0, bus.oIC_done, bus.oDC_done}, 32'h0);
    check("reset oIC_dt", bus.oIC_dt, 32'h0);
    check("reset oDC_dt", bus.oDC_dt, 32'h0);
    check("reset oWait", {30'h0, bus.oWait}, 32'h0);
    check("reset ram port", {bus.oRAM_wr, 23'h0, bus.oRAM_dt} | bus.oRAM_a, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));
    v = '{1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0, 3'd2, 32'h0000_CAFE, 3};
    run_vec(v, "wrap load");

    // Arbitration: both requests at IDLE, dcache first.
    @(negedge clk);
    bus.iIC_en = 1'b1; bus.iIC_pc = 32'h100;
    bus.iDC_en = 1'b1; bus.iDC_ls = 1'b0; bus.iDC_pc = 32'h10; bus.iDC_len = 3'd1;
    @(posedge clk); #1;
    bus.iDC_en = 1'b0;
    dc_at = 0; ic_at = 0; bad_wait = 0; dc_dt_cap = '0; ic_dt_cap = '0;
    if (!bus.oWait[0]) bad_wait = 1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (bus.oDC_done && dc_at == 0) begin
        dc_at = k;
        dc_dt_cap = bus.oDC_dt;
      end
      if (dc_at == 0 && !bus.oWait[0]) bad_wait = 1;
      if (bus.oIC_done) begin
        ic_at = k;
        ic_dt_cap = bus.oIC_dt;
        break;
      end
    end
    bus.iIC_en = 1'b0;
    check("arb dc done edge", 32'(dc_at), 32'd2);
    check("arb ic done edge", 32'(ic_at), 32'd8);
    check("arb dc data", dc_dt_cap, 32'h0000_005A);
    check("arb ic data", ic_dt_cap, 32'h0010_0093);
    check("arb oWait0 during dc", 32'(bad_wait), 32'd0);
    @(posedge clk); #1;

    // Duplicate strobe: iDC_en held over three edges.
    @(negedge clk);
    bus.iDC_en = 1'b1; bus.iDC_ls = 1'b0; bus.iDC_pc = 32'h10; bus.iDC_len = 3'd1;
    ndone = 0; done_c = -1; fall_c = -1;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (c == 2) bus.iDC_en = 1'b0;
      if (bus.oDC_done) begin
        ndone++;
        if (done_c < 0) done_c = c;
      end
      if (done_c >= 0 && c > done_c && fall_c < 0 && !bus.oWait[1]) fall_c = c;
    end
    check("dup done count", 32'(ndone), 32'd1);
    check("dup done edge", 32'(done_c), 32'd2);
    check("dup oWait1 fall edge", 32'(fall_c), 32'd3);
    check("dup data", bus.oDC_dt, 32'h0000_005A);

    // IO stall: store to the IO window while the buffer is full.
    @(negedge clk);
    wbase = wlog.size();
    bus.iDC_en = 1'b1; bus.iDC_ls = 1'b1; bus.iDC_pc = 32'h0003_0000;
    bus.iDC_dt = 32'h41; bus.iDC_len = 3'd1; bus.iIO_full = 1'b1;
    @(posedge clk); #1;
    bus.iDC_en = 1'b0;
    zeros = 0;
    for (int k = 0; k < 3; k++) begin
      #2;
      if (bus.oRAM_wr == 1'b0 && bus.oDC_done == 1'b0) zeros++;
      @(posedge clk);
    end
    #1 bus.iIO_full = 1'b0;
    #1;
    check("io stall cycles", 32'(zeros), 32'd3);
    check("io write beat", {bus.oRAM_wr, bus.oDC_done, 22'h0, bus.oRAM_dt}, 32'h8000_0041);
    check("io write addr", bus.oRAM_a, 32'h0003_0000);
    @(posedge clk); #1;
    check("io done", {31'h0, bus.oDC_done}, 32'h1);
    check("io nwrites", 32'(wlog.size() - wbase), 32'd1);
    @(posedge clk); #1;

    // Reset in the middle of a load after two bytes.
    @(negedge clk);
    bus.iDC_en = 1'b1; bus.iDC_ls = 1'b0; bus.iDC_pc = 32'h200; bus.iDC_len = 3'd4;
    @(posedge clk); #1;
    bus.iDC_en = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("mid reset dones/wait", {28'h0, bus.oWait, bus.oIC_done, bus.oDC_done}, 32'h0);
    check("mid reset oDC_dt", bus.oDC_dt, 32'h0);
    check("mid reset ram port", {bus.oRAM_wr, 23'h0, bus.oRAM_dt} | bus.oRAM_a, 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    ndone = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (bus.oDC_done || bus.oIC_done) ndone++;
    end
    check("mid reset no done", 32'(ndone), 32'd0);

    // rdy low for four cycles in the middle of a store.
    @(negedge clk);
    wbase = wlog.size();
    bus.iDC_en = 1'b1; bus.iDC_ls = 1'b1; bus.iDC_pc = 32'h400;
    bus.iDC_dt = 32'h1122_3344; bus.iDC_len = 3'd4;
    @(posedge clk); #1;
    bus.iDC_en = 1'b0;
    n = 0;
    @(posedge clk); #1;
    n++;
    rdy = 1'b0;
    wr_bad = 0;
    for (int k = 0; k < 4; k++) begin
      #3;
      if (bus.oRAM_wr !== 1'b0 || bus.oDC_done !== 1'b0) wr_bad++;
      @(posedge clk);
      n++;
    end
    #1 rdy = 1'b1;
    while (n < 60) begin
      @(posedge clk); #1;
      n++;
      if (bus.oDC_done) break;
    end
    check("rdy freeze writes", 32'(wr_bad), 32'd0);
    check("rdy store done edge", 32'(n), 32'd8);
    check("rdy nwrites", 32'(wlog.size() - wbase), 32'd4);
    if (wlog.size() - wbase == 4) begin
      check("rdy wr0", {wlog[wbase].a[23:0], wlog[wbase].d}, 32'h0004_0044);
      check("rdy wr1", {wlog[wbase+1].a[23:0], wlog[wbase+1].d}, 32'h0004_0133);
      check("rdy wr2", {wlog[wbase+2].a[23:0], wlog[wbase+2].d}, 32'h0004_0222);
      check("rdy wr3", {wlog[wbase+3].a[23:0], wlog[wbase+3].d}, 32'h0004_0311);
    end
    @(posedge clk); #1;
    v = '{1'b0, 1'b0, 32'h0000_0400, 32'h0, 3'd4, 32'h1122_3344, 5};
    run_vec(v, "rdy readback");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
